axi4_lite_read_slave_pipelined: RTL and testbench
=================================================

Name: axi4_lite_read_slave_pipelined

Overview:
Parametrised AXI4-lite read slave that accepts up to MAX_OUTSTANDING read addresses before any data returns. It forwards in-range reads to a backend over a valid/ready request port and collects in-order backend responses in a buffer. Addresses outside the decoded window are answered with DECERR and never reach the backend. It sits between the AXI interconnect and memory-mapped peripherals or memory that have multi-cycle latency.

Parameters:
ADDR_WIDTH, 32, AXI and backend address width.
DATA_WIDTH, 32, data width; must be 32 or 64.
MAX_OUTSTANDING, 4, maximum accepted-but-unanswered reads; must be a power of 2, at least 2.
BASE_ADDR, 32'h0000_0000, first decoded byte address.
ADDR_SPAN, 32'h0001_0000, decoded window size in bytes; must be a power of 2.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARVALID  in  1  address valid
S_AXI_ARREADY  out  1  address accepted
S_AXI_RDATA  out  DATA_WIDTH  read data
S_AXI_RRESP  out  2  response: 00 OKAY, 10 SLVERR, 11 DECERR
S_AXI_RVALID  out  1  response valid
S_AXI_RREADY  in  1  master ready
req_valid  out  1  backend request valid
req_ready  in  1  backend accepts request
req_addr  out  ADDR_WIDTH  word-aligned backend address
rsp_valid  in  1  backend response; single-cycle pulse, no backpressure
rsp_data  in  DATA_WIDTH  backend read data
rsp_err  in  1  backend error; maps to SLVERR
busy  out  1  outstanding count is non-zero

Behaviour:
- Reset (async, rst=1): all FIFOs empty; outstanding=0; inflight=0; ARREADY=0 while in reset, then 1 from the first clock after release. RVALID=0, RDATA=0, RRESP=0, req_valid=0, req_addr=0, busy=0.
- ARREADY = (outstanding < MAX_OUTSTANDING), from registered state only.
- outstanding: +1 on the AR handshake, -1 on the R handshake. Both in the same cycle leaves it unchanged. It never exceeds MAX_OUTSTANDING.
- AR handshake pushes {addr, decerr} into the address FIFO (depth MAX_OUTSTANDING).
  - decerr = !(BASE_ADDR <= ARADDR < BASE_ADDR+ADDR_SPAN).
  - The low log2(DATA_WIDTH/8) address bits are cleared.
- Issue stage, acting on the address FIFO head:
  - In-range head: req_valid=1 and req_addr=head address. On req_ready, pop the head and increment inflight.
  - DECERR head: pop only when inflight==0, then push {0, 2'b11} into the response FIFO; req_valid stays 0. This preserves AXI response ordering.
- Backend contract: rsp_valid arrives in request order, at least 1 cycle after the req handshake. Only inflight>0 may produce rsp_valid.
- On rsp_valid: push {rsp_data, rsp_err?2'b10:2'b00} into the response FIFO and decrement inflight. If a req handshake and rsp_valid occur in the same cycle, inflight is unchanged.
- Response FIFO depth is MAX_OUTSTANDING, so it can never overflow. The outstanding bound guarantees this.
- R channel:
  - RVALID = response FIFO not empty; RDATA/RRESP = head entry.
  - Pop on RVALID&&RREADY.
  - While RVALID=1 and RREADY=0, RDATA/RRESP are held stable. RVALID is never dropped without a handshake.
- Latency:
  - AR handshake at cycle N gives req_valid at N+1.
  - Backend rsp_valid at M gives RVALID at M+1.
  - DECERR with nothing in flight gives RVALID at N+2.
- Throughput: one transaction per cycle sustained when the backend has 1-cycle latency and RREADY=1.
- Full: with outstanding==MAX_OUTSTANDING, ARREADY=0. An R handshake in cycle K raises ARREADY at K+1.
- Reset mid-operation: all state cleared immediately. Backend responses already in flight are ignored after reset, because inflight=0 and the FIFOs are empty.
- busy = (outstanding != 0).

Decomposition:
- Package axi4_lite_pkg holds:
  - the resp_t enum (OKAY, EXOKAY, SLVERR, DECERR);
  - the AXI_RESP_* constants;
  - the function addr_in_range(addr, base, span).
- Sub-module sync_fifo #(WIDTH, DEPTH): provides push/pop/full/empty and a combinational head output. It is instantiated twice, for the address FIFO and the response FIFO.

Test Plan:
- Single read to 0x0000_0010, backend returns 32'hDEADBEEF after 3 cycles, RREADY=1 -> req_addr=0x10; RDATA=DEADBEEF, RRESP=00 one cycle after rsp_valid; busy returns to 0.
- 4 back-to-back ARs (0x0,0x4,0x8,0xC), RREADY=0 -> ARREADY drops after the 4th; a 5th AR stalls. Raising RREADY returns data in order 0x0..0xC. ARREADY reasserts the cycle after the first R handshake.
- AR 0x0002_0000 (out of window) while idle -> no req_valid; RRESP=11, RDATA=0 at N+2.
- AR 0x4 (backend latency 5), then AR 0x0003_0000 -> DECERR response appears strictly after the OKAY for 0x4.
- Backend responds with rsp_err=1 to AR 0x8 -> RRESP=10 with rsp_data passed through.
- Assert rst while 2 reads are outstanding and RVALID=1 -> RVALID, req_valid and busy are 0 immediately. After release, a fresh read to 0x0 completes normally with OKAY.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-lite read-side definitions.
//   resp_t          : RRESP encoding
//   AXI_RESP_*      : raw RRESP codes
//   addr_in_range() : window decode helper, evaluated at 64 bits so base+span cannot wrap
package axi4_lite_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        RESP_OKAY   = AXI_RESP_OKAY,
        RESP_EXOKAY = AXI_RESP_EXOKAY,
        RESP_SLVERR = AXI_RESP_SLVERR,
        RESP_DECERR = AXI_RESP_DECERR
    } resp_t;

    // True when base <= addr < base + span.
    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input logic [63:0] base,
                                           input logic [63:0] span);
        return (addr >= base) && ((addr - base) < span);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a combinational head (show-ahead) output.
//   clk, rst        : clock, asynchronous active-high reset
//   push, push_data : write port; ignored while full
//   pop             : remove head; ignored while empty
//   head            : current head entry
//   full, empty     : occupancy flags
// DEPTH must be a power of 2 so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    assign head  = mem[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/axi4_lite_read_slave_pipelined.sv
// Pipelined AXI4-lite read slave with up to MAX_OUTSTANDING accepted reads.
//   clk, rst              : clock, asynchronous active-high reset
//   S_AXI_AR*             : read address channel
//   S_AXI_R*              : read data channel (in order, OKAY/SLVERR/DECERR)
//   req_valid/ready/addr  : backend request port, word-aligned address
//   rsp_valid/data/err    : backend response, in request order, no backpressure
//   busy                  : at least one read accepted but not yet answered
// In-window reads go to the backend; out-of-window reads are answered with
// DECERR once every earlier backend request has returned, keeping R in order.
module axi4_lite_read_slave_pipelined
    import axi4_lite_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter int unsigned           MAX_OUTSTANDING = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = ADDR_WIDTH'(32'h0000_0000),
    parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN       = ADDR_WIDTH'(32'h0001_0000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  rsp_err,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned LSB_W = $clog2(DATA_WIDTH / 8);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  decerr;
    } ar_entry_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        resp_t                 resp;
    } r_entry_t;

    localparam int unsigned AR_W = $bits(ar_entry_t);
    localparam int unsigned R_W  = $bits(r_entry_t);

    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic             arready_q;
    logic             busy_q;

    ar_entry_t ar_push_data, ar_head;
    r_entry_t  r_push_data, r_head;
    logic      ar_full, ar_empty, ar_pop;
    logic      r_full, r_empty, r_push;
    logic      ar_hs, r_hs, req_hs, decerr_pop, rsp_accept;

    assign ar_hs = S_AXI_ARVALID && arready_q;
    assign r_hs  = S_AXI_RVALID && S_AXI_RREADY;

    // Address FIFO entry: aligned address plus window decode result.
    always_comb begin
        ar_push_data        = '0;
        ar_push_data.addr   = {S_AXI_ARADDR[ADDR_WIDTH-1:LSB_W], {LSB_W{1'b0}}};
        ar_push_data.decerr = !addr_in_range(64'(S_AXI_ARADDR), 64'(BASE_ADDR), 64'(ADDR_SPAN));
    end

    sync_fifo #(.WIDTH(AR_W), .DEPTH(MAX_OUTSTANDING)) u_ar_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ar_hs && !ar_full),
        .push_data (ar_push_data),
        .pop       (ar_pop),
        .head      (ar_head),
        .full      (ar_full),
        .empty     (ar_empty)
    );

    // Issue stage. A DECERR head waits for the backend to drain so its
    // response cannot overtake older in-flight reads.
    assign req_valid  = !ar_empty && !ar_head.decerr;
    assign req_addr   = req_valid ? ar_head.addr : '0;
    assign req_hs     = req_valid && req_ready;
    assign decerr_pop = !ar_empty && ar_head.decerr && (inflight_q == '0);
    assign ar_pop     = req_hs || decerr_pop;

    // Responses arriving with nothing in flight (e.g. across a reset) are dropped.
    assign rsp_accept = rsp_valid && (inflight_q != '0);
    assign r_push     = rsp_accept || decerr_pop;

    // Response FIFO entry; backend and DECERR pushes are mutually exclusive.
    always_comb begin
        r_push_data = '0;
        if (decerr_pop) begin
            r_push_data.resp = RESP_DECERR;
        end else begin
            r_push_data.data = rsp_data;
            r_push_data.resp = rsp_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    sync_fifo #(.WIDTH(R_W), .DEPTH(MAX_OUTSTANDING)) u_r_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_push && !r_full),
        .push_data (r_push_data),
        .pop       (r_hs),
        .head      (r_head),
        .full      (r_full),
        .empty     (r_empty)
    );

    assign S_AXI_RVALID = !r_empty;
    assign S_AXI_RDATA  = r_empty ? '0 : r_head.data;
    assign S_AXI_RRESP  = r_empty ? AXI_RESP_OKAY : r_head.resp;

    // Next-state counters.
    always_comb begin
        outstanding_d = outstanding_q;
        case ({ar_hs, r_hs})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: ;
        endcase

        inflight_d = inflight_q;
        case ({req_hs, rsp_accept})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: ;
        endcase
    end

    // Counter and flag registers; ARREADY/busy look one cycle ahead of outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_q <= '0;
            inflight_q    <= '0;
            arready_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            inflight_q    <= inflight_d;
            arready_q     <= (outstanding_d < CNT_W'(MAX_OUTSTANDING));
            busy_q        <= (outstanding_d != '0);
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_axi4_lite_read_slave_pipelined.sv
// Scoreboard bench for axi4_lite_read_slave_pipelined: stimulus pushes the
// expected backend requests and R responses; a backend model and an R monitor
// consume them independently.
module tb_axi4_lite_read_slave_pipelined;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] S_AXI_ARADDR;
    logic          S_AXI_ARVALID;
    logic          S_AXI_ARREADY;
    logic [DW-1:0] S_AXI_RDATA;
    logic [1:0]    S_AXI_RRESP;
    logic          S_AXI_RVALID;
    logic          S_AXI_RREADY;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          busy;

    typedef struct { logic [AW-1:0] addr; int lat; logic [DW-1:0] data; logic err; } be_t;
    typedef struct { int due; logic [DW-1:0] data; logic err; } pend_t;
    typedef struct { logic [DW-1:0] data; logic [1:0] resp; } exp_t;

    be_t   be_q[$];
    pend_t pend_q[$];
    exp_t  exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_req_cyc = -1;

    axi4_lite_read_slave_pipelined #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO),
        .BASE_ADDR(32'h0000_0000), .ADDR_SPAN(32'h0001_0000)
    ) dut (
        .clk(clk), .rst(rst),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Backend model: checks each request address and returns data after its latency.
    initial begin
        be_t b;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        forever begin
            @(posedge clk); #1;
            rsp_valid = 1'b0;
            rsp_data  = '0;
            rsp_err   = 1'b0;
            if (!rst && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                rsp_valid = 1'b1;
                rsp_data  = pend_q[0].data;
                rsp_err   = pend_q[0].err;
                void'(pend_q.pop_front());
            end
            @(negedge clk);
            if (rst) begin
                pend_q.delete();
            end else if (req_valid && req_ready) begin
                if (be_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req actual=%0h required=none", req_addr);
                end else begin
                    b = be_q.pop_front();
                    chk("req_addr", 64'(req_addr), 64'(b.addr));
                    pend_q.push_back('{cyc + b.lat, b.data, b.err});
                    last_req_cyc = cyc;
                end
            end
        end
    end

    // R monitor: in-order scoreboard plus hold-stable checks while stalled.
    initial begin
        logic          held;
        logic [DW-1:0] hd;
        logic [1:0]    hr;
        exp_t          e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else if (S_AXI_RVALID) begin
                if (held) begin
                    chk("rdata_stable", 64'(S_AXI_RDATA), 64'(hd));
                    chk("rresp_stable", 64'(S_AXI_RRESP), 64'(hr));
                end
                if (S_AXI_RREADY) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp actual=%0h/%0h required=none", S_AXI_RDATA, S_AXI_RRESP);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rdata", 64'(S_AXI_RDATA), 64'(e.data));
                        chk("rresp", 64'(S_AXI_RRESP), 64'(e.resp));
                    end
                end else begin
                    held = 1'b1;
                    hd   = S_AXI_RDATA;
                    hr   = S_AXI_RRESP;
                end
            end else if (held) begin
                checks++;
                errors++;
                $display("FAIL rvalid_dropped actual=0 required=1");
                held = 1'b0;
            end
        end
    end

    // Issue one AR starting at posedge+1; returns the handshake cycle, ends at posedge+1.
    task automatic ar(input logic [AW-1:0] addr, output int hs_cyc);
        bit done = 1'b0;
        int n = 0;
        hs_cyc = -1;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        while (!done && n < 50) begin
            @(negedge clk);
            if (S_AXI_ARREADY) begin
                done   = 1'b1;
                hs_cyc = cyc;
            end
            @(posedge clk); #1;
            n++;
        end
        S_AXI_ARVALID = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL ar_timeout addr=%0h actual=stalled required=accepted", addr);
        end
    endtask

    // Cycle in which RVALID is first seen high, -1 on timeout.
    task automatic wait_rvalid(output int c);
        c = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (S_AXI_RVALID) begin
                c = cyc;
                break;
            end
        end
    endtask

    // Wait until all expectations are consumed and busy drops; ends at posedge+1.
    task automatic drain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && be_q.size() == 0 && pend_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 64'(ok), 64'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c;
        int hs[6];
        int stall_acc;

        rst = 1'b1;
        S_AXI_ARADDR = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        req_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", 64'(S_AXI_ARREADY), 64'(0));
        chk("rst_rvalid", 64'(S_AXI_RVALID), 64'(0));
        chk("rst_rdata", 64'(S_AXI_RDATA), 64'(0));
        chk("rst_rresp", 64'(S_AXI_RRESP), 64'(0));
        chk("rst_req_valid", 64'(req_valid), 64'(0));
        chk("rst_req_addr", 64'(req_addr), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("arready_after_rst", 64'(S_AXI_ARREADY), 64'(1));

        // Single read, backend latency 3
        S_AXI_RREADY = 1'b1;
        be_q.push_back('{32'h10, 3, 32'hDEAD_BEEF, 1'b0});
        exp_q.push_back('{32'hDEAD_BEEF, 2'b00});
        ar(32'h0000_0010, n);
        wait_rvalid(c);
        chk("t1_req_latency", 64'(last_req_cyc), 64'(n + 1));
        chk("t1_rvalid_latency", 64'(c), 64'(n + 5));
        drain("t1_drain");

        // Fill to MAX_OUTSTANDING with RREADY low; 5th AR stalls
        S_AXI_RREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            be_q.push_back('{AW'(i * 4), 1, 32'hA000_0000 + DW'(i), 1'b0});
            exp_q.push_back('{32'hA000_0000 + DW'(i), 2'b00});
        end
        be_q.push_back('{32'h14, 1, 32'hA000_0004, 1'b0});
        exp_q.push_back('{32'hA000_0004, 2'b00});
        for (int i = 0; i < 4; i++) ar(AW'(i * 4), hs[i]);
        chk("t2_back_to_back", 64'(hs[3] - hs[0]), 64'(3));
        chk("t2_full_arready", 64'(S_AXI_ARREADY), 64'(0));
        S_AXI_ARADDR  = 32'h14;
        S_AXI_ARVALID = 1'b1;
        stall_acc = 0;
        repeat (8) begin
            @(negedge clk);
            if (S_AXI_ARREADY) stall_acc++;
            @(posedge clk); #1;
        end
        chk("t2_ar_stall", 64'(stall_acc), 64'(0));
        S_AXI_RREADY = 1'b1;
        @(negedge clk);
        chk("t2_arready_hs_cycle", 64'(S_AXI_ARREADY), 64'(0));
        @(posedge clk); #1;
        chk("t2_arready_next_cycle", 64'(S_AXI_ARREADY), 64'(1));
        @(posedge clk); #1;
        S_AXI_ARVALID = 1'b0;
        drain("t2_drain");

        // Out-of-window read while idle
        exp_q.push_back('{32'h0, 2'b11});
        ar(32'h0002_0000, n);
        wait_rvalid(c);
        chk("t3_decerr_latency", 64'(c), 64'(n + 2));
        drain("t3_drain");

        // DECERR behind a slow in-window read keeps order
        be_q.push_back('{32'h4, 5, 32'h1234_5678, 1'b0});
        exp_q.push_back('{32'h1234_5678, 2'b00});
        exp_q.push_back('{32'h0, 2'b11});
        ar(32'h0000_0004, n);
        ar(32'h0003_0000, n);
        drain("t4_drain");

        // Backend error maps to SLVERR with data passed through
        be_q.push_back('{32'h8, 2, 32'hBAD0_0BAD, 1'b1});
        exp_q.push_back('{32'hBAD0_0BAD, 2'b10});
        ar(32'h0000_0008, n);
        drain("t5_drain");

        // Sustained one-per-cycle throughput, unaligned address gets aligned
        for (int i = 0; i < 6; i++) begin
            be_q.push_back('{32'h20 + AW'(i * 4), 1, 32'hC000_0000 + DW'(i), 1'b0});
            exp_q.push_back('{32'hC000_0000 + DW'(i), 2'b00});
        end
        for (int i = 0; i < 6; i++) ar(32'h20 + AW'(i * 4) + AW'(i % 4), hs[i]);
        chk("t7_sustained", 64'(hs[5] - hs[0]), 64'(5));
        drain("t7_drain");

        // Reset with two reads outstanding and RVALID high
        S_AXI_RREADY = 1'b0;
        be_q.push_back('{32'h0, 1, 32'h1111_1111, 1'b0});
        be_q.push_back('{32'h4, 1, 32'h2222_2222, 1'b0});
        exp_q.push_back('{32'h1111_1111, 2'b00});
        exp_q.push_back('{32'h2222_2222, 2'b00});
        ar(32'h0, n);
        ar(32'h4, n);
        wait_rvalid(c);
        chk("t6_rvalid_before_rst", 64'(S_AXI_RVALID), 64'(1));
        chk("t6_busy_before_rst", 64'(busy), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_rvalid", 64'(S_AXI_RVALID), 64'(0));
        chk("t6_rst_req_valid", 64'(req_valid), 64'(0));
        chk("t6_rst_busy", 64'(busy), 64'(0));
        exp_q.delete();
        be_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        S_AXI_RREADY = 1'b1;
        be_q.push_back('{32'h0, 2, 32'hCAFE_F00D, 1'b0});
        exp_q.push_back('{32'hCAFE_F00D, 2'b00});
        ar(32'h0, n);
        drain("t6_drain");

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
